// File: rtl/srt4_host_driver.sv
// Host-side initiator for the SRT-4 divider serial bus.
// Sends dividend then divisor, collects quotient then remainder.
module srt4_host_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_dividend,
  input  logic [7:0] req_divisor,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_quotient,
  output logic [7:0] rsp_remainder,
  output logic       rsp_div_by_zero,
  output logic       rsp_timeout,
  output logic       beginSignal,
  output logic [7:0] inbus,
  input  logic [7:0] outbus,
  input  logic       endSignal
);

  typedef enum logic [2:0] {
    IDLE, SEND_A, SEND_B, WAIT, CAP_R, RESP
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [7:0] divisor_q;
  logic       cnt_done;
  logic       req_fire;

  assign cnt_done = (cnt == 8'(TIMEOUT_CYCLES - 1));
  assign req_fire = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (req_fire)
          state_nxt = (req_divisor == 8'd0) ? RESP : SEND_A;
      SEND_A: state_nxt = SEND_B;
      SEND_B: state_nxt = WAIT;
      WAIT:
        if (endSignal)     state_nxt = CAP_R;
        else if (cnt_done) state_nxt = RESP;
      CAP_R: state_nxt = RESP;
      RESP:
        if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Completion is checked before the timeout so a same-cycle endSignal wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_quotient    <= 8'd0;
      rsp_remainder   <= 8'd0;
      rsp_div_by_zero <= 1'b0;
      rsp_timeout     <= 1'b0;
      beginSignal     <= 1'b0;
      inbus           <= 8'd0;
      cnt             <= 8'd0;
      divisor_q       <= 8'd0;
    end else begin
      req_ready <= (state_nxt == IDLE);
      unique case (state)
        IDLE:
          if (req_fire) begin
            divisor_q <= req_divisor;
            if (req_divisor == 8'd0) begin
              rsp_quotient    <= 8'hFF;
              rsp_remainder   <= req_dividend;
              rsp_div_by_zero <= 1'b1;
              rsp_valid       <= 1'b1;
            end else begin
              beginSignal <= 1'b1;
              inbus       <= req_dividend;
            end
          end
        SEND_A: begin
          beginSignal <= 1'b0;
          inbus       <= divisor_q;
        end
        SEND_B: begin
          inbus <= 8'd0;
          cnt   <= 8'd0;
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (endSignal) begin
            rsp_quotient <= outbus;
          end else if (cnt_done) begin
            rsp_quotient  <= 8'd0;
            rsp_remainder <= 8'd0;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
          end
        end
        CAP_R: begin
          rsp_remainder <= outbus;
          rsp_valid     <= 1'b1;
        end
        RESP:
          if (rsp_ready) begin
            rsp_valid       <= 1'b0;
            rsp_div_by_zero <= 1'b0;
            rsp_timeout     <= 1'b0;
          end
        default: ;
      endcase
    end
  end

endmodule
